// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit arbiter
package uart_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  // Clocks per bit, rounded to the nearest integer
  function automatic int uart_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 frame serializer with its own baud counter
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DIVISOR = 868,
  parameter int NSTOP   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_idle,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int             CW       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0]  BAUD_TOP = CW'(DIVISOR - 1);
  // Frame bit index: 0 start, 1..8 data, 9..8+NSTOP stop
  localparam logic [3:0]     LAST_BIT = 4'(8 + NSTOP);

  logic [CW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_busy;
  logic          r_tx;

  logic w_bit_end;
  logic w_frame_end;

  assign w_bit_end   = (r_baud == '0);
  assign w_frame_end = r_busy && w_bit_end && (r_bit == LAST_BIT);

  // Idle already in the last clock of the final stop bit so frames can abut
  assign o_idle = !r_busy || w_frame_end;
  assign o_busy = r_busy;
  assign o_tx   = r_tx;

  // Load a byte, then step through the frame one bit per DIVISOR clocks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx    <= UART_IDLE;
      r_busy  <= 1'b0;
      r_baud  <= BAUD_TOP;
      r_bit   <= 4'd0;
      r_shift <= 8'hFF;
    end else if (i_load) begin
      r_tx    <= UART_START;
      r_busy  <= 1'b1;
      r_baud  <= BAUD_TOP;
      r_bit   <= 4'd0;
      r_shift <= i_data;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_baud <= BAUD_TOP;
        if (r_bit == LAST_BIT) begin
          r_busy <= 1'b0;
          r_tx   <= UART_IDLE;
          r_bit  <= 4'd0;
        end else begin
          // Shifting in ones makes the stop bits fall out of the register
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[7:1]};
        end
      end else begin
        r_baud <= r_baud - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message-locking arbiter onto one UART tx line
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int NSTOP        = 1,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_valid,
  input  logic [8*NREQ-1:0] i_data,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_ready,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_UART_Tx
);

  localparam int            DIVISOR = uart_divisor(CLK_FREQ_HZ, BAUD);
  localparam int            IW      = $clog2(NREQ);
  localparam int            TW      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_grant;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [TW-1:0]   r_idle_cnt;
  logic            r_timeout;

  logic [NREQ-1:0] w_ready;
  logic            w_xfer;
  logic            w_xfer_last;
  logic            w_ser_idle;
  logic            w_owner_valid;
  logic [7:0]      w_data;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;

  assign w_ready       = (r_state == LOCKED && w_ser_idle) ? (r_grant & i_valid) : '0;
  assign w_xfer        = |w_ready;
  assign w_xfer_last   = |(w_ready & i_last);
  assign w_owner_valid = i_valid[r_owner];
  assign w_data        = i_data[{r_owner, 3'b000} +: 8];

  assign o_ready   = w_ready;
  assign o_grant   = r_grant;
  assign o_timeout = r_timeout;

  // First valid requester searching upward from the one after the pointer
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && i_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Arbiter FSM: grant, hold the lock until a last byte or idle timeout
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= IW'(NREQ - 1);
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_idle_cnt <= '0;
          if (w_found) begin
            r_state <= LOCKED;
            r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
            r_owner <= w_pick;
          end
        end
        LOCKED: begin
          if (w_xfer_last) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= r_owner;
            r_idle_cnt <= '0;
          end else if ((IDLE_TIMEOUT > 0) && w_ser_idle && !w_owner_valid) begin
            if (r_idle_cnt == TO_LAST) begin
              r_state    <= IDLE;
              r_grant    <= '0;
              r_ptr      <= r_owner;
              r_idle_cnt <= '0;
              r_timeout  <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end else begin
            r_idle_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_tx_serializer #(
    .DIVISOR (DIVISOR),
    .NSTOP   (NSTOP)
  ) u_ser (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_xfer),
    .i_data (w_data),
    .o_idle (w_ser_idle),
    .o_busy (o_busy),
    .o_tx   (o_UART_Tx)
  );

endmodule
